mod_counter_n: RTL and testbench



---
 rtl/counter_pkg.sv | 18 +
 rtl/mod_counter_n.sv | 75 +++++++
 tb/tb_mod_counter_n.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared helpers and constants for the presettable modulus counter family.
package counter_pkg;

  // Values for the SATURATE parameter
  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  // Terminal value for the current direction: top of range counting up, zero counting down
  function automatic int unsigned term_val(input logic up, input int unsigned modulus);
    return up ? modulus - 1 : 0;
  endfunction

  // Load data outside the count range is pulled down to the top of the range
  function automatic int unsigned clamp_load(input int unsigned d, input int unsigned modulus);
    return (d >= modulus) ? modulus - 1 : d;
  endfunction

endpackage

// File: rtl/mod_counter_n.sv
// Parametrised presettable up/down counter with modulus, wrap/saturate mode,
// chainable enables, combinational ripple carry and a registered wrap pulse.
// Legal ranges: WIDTH 1..16, MODULUS 2..2**WIDTH.
module mod_counter_n
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = CNT_WRAP
) (
  input  logic             CP,
  input  logic             clear,
  input  logic             C_R,
  input  logic             L_D,
  input  logic             CT_P,
  input  logic             CT_T,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Co,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam bit               SatMode = (SATURATE == CNT_SAT);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] load_val;
  logic             at_term;

  assign term     = WIDTH'(term_val(UP, MODULUS));
  assign load_val = WIDTH'(clamp_load(32'(D), MODULUS));
  // Explicit compare even when MODULUS == 2**WIDTH so Q can never leave the range
  assign at_term  = (q_q == term);

  // Next-state: sync clear, then load, then enabled count, else hold
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!C_R) begin
      q_d = '0;
    end else if (!L_D) begin
      q_d = load_val;
    end else if (CT_P && CT_T) begin
      if (at_term) begin
        if (!SatMode) begin
          q_d    = UP ? '0 : MaxVal;
          wrap_d = 1'b1;
        end
      end else begin
        q_d = UP ? (q_q + One) : (q_q - One);
      end
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge CP or posedge clear) begin
    if (clear) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // Carry is combinational so the next stage can enable in the same cycle
  assign Co   = CT_T & at_term;
  assign Q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_counter_n.sv
// Self-checking bench for mod_counter_n: directed vector table, hand-written
// corner sequences, a BCD cascade and randomized traffic against a modulo model.
module tb_mod_counter_n;
  import counter_pkg::*;

  logic       CP = 1'b0;
  logic       clear;
  logic       c_r, l_d, ct_p, ct_t, up;
  logic [3:0] d;

  // Shared-control instances: M10 wrap, M10 saturate, M16 wrap, M5 (3-bit) wrap
  logic [3:0] q_a, q_b, q_c;
  logic [2:0] q_e;
  logic       co_a, co_b, co_c, co_e;
  logic       wr_a, wr_b, wr_c, wr_e;

  // BCD cascade
  logic       cas_ce;
  logic [3:0] q_lo, q_hi;
  logic       co_lo, co_hi, wr_lo, wr_hi;

  int checks   = 0;
  int failures = 0;

  always #5 CP = ~CP;

  mod_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_a (
    .CP(CP), .clear(clear), .C_R(c_r), .L_D(l_d), .CT_P(ct_p), .CT_T(ct_t), .UP(up),
    .D(d), .Q(q_a), .Co(co_a), .wrap(wr_a));
  mod_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_SAT)) u_b (
    .CP(CP), .clear(clear), .C_R(c_r), .L_D(l_d), .CT_P(ct_p), .CT_T(ct_t), .UP(up),
    .D(d), .Q(q_b), .Co(co_b), .wrap(wr_b));
  mod_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(CNT_WRAP)) u_c (
    .CP(CP), .clear(clear), .C_R(c_r), .L_D(l_d), .CT_P(ct_p), .CT_T(ct_t), .UP(up),
    .D(d), .Q(q_c), .Co(co_c), .wrap(wr_c));
  mod_counter_n #(.WIDTH(3), .MODULUS(5), .SATURATE(CNT_WRAP)) u_e (
    .CP(CP), .clear(clear), .C_R(c_r), .L_D(l_d), .CT_P(ct_p), .CT_T(ct_t), .UP(up),
    .D(d[2:0]), .Q(q_e), .Co(co_e), .wrap(wr_e));

  mod_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_lo (
    .CP(CP), .clear(clear), .C_R(1'b1), .L_D(1'b1), .CT_P(cas_ce), .CT_T(cas_ce),
    .UP(1'b1), .D(4'd0), .Q(q_lo), .Co(co_lo), .wrap(wr_lo));
  mod_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_hi (
    .CP(CP), .clear(clear), .C_R(1'b1), .L_D(1'b1), .CT_P(cas_ce), .CT_T(co_lo),
    .UP(1'b1), .D(4'd0), .Q(q_hi), .Co(co_hi), .wrap(wr_hi));

  typedef struct {
    logic       c_r, l_d, ct_p, ct_t, up;
    logic [3:0] d;
    int         q;
    logic       co, wr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic set_in(input logic cr, input logic ld, input logic p, input logic t,
                        input logic u, input logic [3:0] dv);
    c_r = cr; l_d = ld; ct_p = p; ct_t = t; up = u; d = dv;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    #1;
    clear = 1'b0;
  endtask

  // Reference: counting is arithmetic modulo m; wrap marks crossing the terminal value
  function automatic void model_step(input int q, input int m, input bit sat,
                                     input logic cr, input logic ld, input logic p,
                                     input logic t, input logic u, input int dv,
                                     output int qn, output bit wr);
    wr = 1'b0;
    qn = q;
    if (!cr) qn = 0;
    else if (!ld) qn = (dv < m) ? dv : m - 1;
    else if (p && t) begin
      if (sat && q == (u ? m - 1 : 0)) qn = q;
      else begin
        qn = u ? (q + 1) % m : (q + m - 1) % m;
        wr = !sat && (u ? (q == m - 1) : (q == 0));
      end
    end
  endfunction

  function automatic int dut_q(input int i);
    case (i)
      0: return int'(q_a);
      1: return int'(q_b);
      2: return int'(q_c);
      default: return int'(q_e);
    endcase
  endfunction

  function automatic logic dut_co(input int i);
    case (i)
      0: return co_a;
      1: return co_b;
      2: return co_c;
      default: return co_e;
    endcase
  endfunction

  function automatic logic dut_wr(input int i);
    case (i)
      0: return wr_a;
      1: return wr_b;
      2: return wr_c;
      default: return wr_e;
    endcase
  endfunction

  initial begin
    int  mods[4];
    bit  sats[4];
    int  dmask[4];
    int  mq[4];
    bit  mw[4];
    int  exp_q;

    mods  = '{10, 10, 16, 5};
    sats  = '{1'b0, 1'b1, 1'b0, 1'b0};
    dmask = '{15, 15, 15, 7};

    //            c_r   l_d   p     t     up    d      q  co    wr
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5,  0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd13, 9, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  9, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2,  2, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  9, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 9, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd10, 9, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  9, 1'b0, 1'b0};

    // Reset state
    clear  = 1'b1;
    cas_ce = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    check("reset_q_a", q_a, 0);
    check("reset_wrap_a", wr_a, 0);
    check("reset_co_a", co_a, 0);
    check("reset_q_e", q_e, 0);
    clear = 1'b0;

    // Directed vector table on the M10 wrap instance
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].c_r, vecs[i].l_d, vecs[i].ct_p, vecs[i].ct_t, vecs[i].up, vecs[i].d);
      tick();
      check($sformatf("vec%0d_q", i), q_a, vecs[i].q);
      check($sformatf("vec%0d_co", i), co_a, vecs[i].co);
      check($sformatf("vec%0d_wrap", i), wr_a, vecs[i].wr);
    end

    // Asynchronous clear mid-cycle, no clock edge needed
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    check("preclr_q", q_a, 7);
    l_d = 1'b1;
    #2 clear = 1'b1;
    #1;
    check("async_clr_q", q_a, 0);
    check("async_clr_wrap", wr_a, 0);
    clear = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    tick();
    check("prewrap_wrap", wr_a, 1);
    ct_p = 1'b0;
    #2 clear = 1'b1;
    #1;
    check("async_clr_wrap2", wr_a, 0);
    clear = 1'b0;

    // Up-count wrap run from 0
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    #1;
    check("upwrap_start_co", co_a, 0);
    for (int i = 0; i < 11; i++) begin
      tick();
      exp_q = (i + 1) % 10;
      check($sformatf("upwrap%0d_q", i), q_a, exp_q);
      check($sformatf("upwrap%0d_co", i), co_a, exp_q == 9);
      check($sformatf("upwrap%0d_wrap", i), wr_a, exp_q == 0);
    end

    // Saturation: hold at 9 without wrap, then step down on direction flip
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd8);
    tick();
    check("sat_load_q", q_b, 8);
    l_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sat%0d_q", i), q_b, 9);
      check($sformatf("sat%0d_wrap", i), wr_b, 0);
      check($sformatf("sat%0d_co", i), co_b, 1);
    end
    up = 1'b0;
    tick();
    check("sat_down_q", q_b, 8);

    // BCD cascade 00..99 then 00
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    pulse_clear();
    cas_ce = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      exp_q = (i + 1) % 100;
      check($sformatf("bcd%0d", i), int'(q_hi) * 10 + int'(q_lo), exp_q);
    end
    cas_ce = 1'b0;

    // Randomized traffic against the modulo model
    pulse_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k] = 0;
      mw[k] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      c_r  = ($urandom_range(0, 19) != 0);
      l_d  = ($urandom_range(0, 9) != 0);
      ct_p = ($urandom_range(0, 4) != 0);
      ct_t = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 4) == 0) up = ~up;
      d    = 4'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < 4; k++)
        check($sformatf("rnd%0d_co%0d", n, k), dut_co(k),
              ct_t && (mq[k] == (up ? mods[k] - 1 : 0)));
      @(posedge CP);
      for (int k = 0; k < 4; k++)
        model_step(mq[k], mods[k], sats[k], c_r, l_d, ct_p, ct_t, up,
                   int'(d) & dmask[k], mq[k], mw[k]);
      #1;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rnd%0d_q%0d", n, k), dut_q(k), mq[k]);
        check($sformatf("rnd%0d_wrap%0d", n, k), dut_wr(k), mw[k]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
